cgr_decoder: RTL and testbench

- Inverse of the CGR address generator: accepts a 16-bit CGR address {addr_x, addr_y} and replays the K 2-bit symbols that produced it, oldest first.
- Used for k-mer readback and debug dump of table hits, and as the loopback checker for the address generator.
- Upstream is the table or index reader (valid/ready); downstream is the symbol consumer (valid/ready, may stall).

---
 rtl/cgr_pkg.sv | 18 +
 rtl/cgr_coord_unshift.sv | 37 +++
 rtl/cgr_decoder.sv | 115 +++++++++++
 tb/tb_cgr_decoder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgr_pkg.sv
// Shared CGR definitions: k-mer length, symbol encoding and the decoder FSM states.
// Also used by the CGR address generator.
package cgr_pkg;

    localparam int CGR_DATA_LEN = 8;
    localparam int SYM_W        = 2;

    localparam logic [SYM_W-1:0] SYM_A = 2'b00;
    localparam logic [SYM_W-1:0] SYM_C = 2'b01;
    localparam logic [SYM_W-1:0] SYM_G = 2'b10;
    localparam logic [SYM_W-1:0] SYM_T = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/cgr_coord_unshift.sv
// One CGR coordinate: parallel load, then shift right so bit 0 (the oldest symbol bit)
// is always presented first.
module cgr_coord_unshift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         bit0
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // Load wins over shift so a back-to-back reload replaces the spent coordinate.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = sr_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit0 = sr_q[0];

endmodule

// File: rtl/cgr_decoder.sv
// CGR address decoder: replays the DATA_LEN symbols behind a {addr_x, addr_y} address,
// oldest first.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid, once raised, holds its payload until the transfer; ready may depend on valid.
module cgr_decoder
    import cgr_pkg::*;
#(
    parameter int DATA_LEN = CGR_DATA_LEN
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [2*DATA_LEN-1:0]   addr_in,
    input  logic                    addr_valid,
    output logic                    addr_ready,
    output logic [SYM_W-1:0]        symbol,
    output logic                    symbol_valid,
    input  logic                    symbol_ready,
    output logic                    symbol_last,
    output logic                    busy
);

    localparam int ADDR_W = 2 * DATA_LEN;
    localparam int CNT_W  = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LEN - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic x_bit0;
    logic y_bit0;
    logic at_last;
    logic load;
    logic shift;

    assign at_last    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign addr_ready = (state_q == IDLE) || (at_last && symbol_ready);
    assign load       = addr_valid && addr_ready;
    assign shift      = (state_q == SHIFT) && symbol_ready && !at_last;

    cgr_coord_unshift #(.W(DATA_LEN)) u_x (
        .clk   (CLK),
        .rst   (RST),
        .load  (load),
        .shift (shift),
        .d     (addr_in[ADDR_W-1:DATA_LEN]),
        .bit0  (x_bit0)
    );

    cgr_coord_unshift #(.W(DATA_LEN)) u_y (
        .clk   (CLK),
        .rst   (RST),
        .load  (load),
        .shift (shift),
        .d     (addr_in[DATA_LEN-1:0]),
        .bit0  (y_bit0)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (load) begin
                    cnt_d = '0;
                end else if (shift) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (at_last && symbol_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Symbol is forced to zero outside SHIFT so IDLE never shows stale shifter bits.
    always_comb begin
        symbol_valid = 1'b0;
        symbol       = '0;
        symbol_last  = 1'b0;
        busy         = 1'b0;
        case (state_q)
            SHIFT: begin
                symbol_valid = 1'b1;
                symbol       = {x_bit0, y_bit0};
                symbol_last  = at_last;
                busy         = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cgr_decoder.sv
// Self-checking bench for cgr_decoder: directed scenarios plus a randomized loopback
// against a symbol-queue model of the decoder.
module tb_cgr_decoder;
    import cgr_pkg::*;

    localparam int K = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] addr_in = '0;
    logic        addr_valid = 1'b0;
    logic        addr_ready;
    logic [1:0]  symbol;
    logic        symbol_valid;
    logic        symbol_ready = 1'b0;
    logic        symbol_last;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Remaining symbols of the address in flight, each entry {last, symbol}.
    logic [2:0] exp_q[$];
    logic [5:0] obs;
    logic [5:0] exp;

    always #5 CLK = ~CLK;

    cgr_decoder dut (
        .CLK          (CLK),
        .RST          (RST),
        .addr_in      (addr_in),
        .addr_valid   (addr_valid),
        .addr_ready   (addr_ready),
        .symbol       (symbol),
        .symbol_valid (symbol_valid),
        .symbol_ready (symbol_ready),
        .symbol_last  (symbol_last),
        .busy         (busy)
    );

    function automatic logic [1:0] ref_sym(input logic [15:0] a, input int i);
        return 2'((((a >> (K + i)) & 16'd1) * 2) + ((a >> i) & 16'd1));
    endfunction

    // Expected {addr_ready, symbol_valid, symbol, symbol_last, busy} for this cycle.
    function automatic logic [5:0] model_out(input logic rdy);
        int n = exp_q.size();
        if (n == 0) return 6'b100000;
        return {(n == 1) && rdy, 1'b1, exp_q[0][1:0], n == 1, 1'b1};
    endfunction

    task automatic model_clock(input logic v, input logic [15:0] a, input logic r);
        int n = exp_q.size();
        logic acc = v && ((n == 0) || ((n == 1) && r));
        if (r && n > 0) void'(exp_q.pop_front());
        if (acc) begin
            for (int i = 0; i < K; i++) exp_q.push_back({i == K - 1, ref_sym(a, i)});
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic r);
        @(negedge CLK);
        addr_valid   = v;
        addr_in      = a;
        symbol_ready = r;
        #1;
        obs = {addr_ready, symbol_valid, symbol, symbol_last, busy};
    endtask

    task automatic test_reset();
        #1;
        obs = {addr_ready, symbol_valid, symbol, symbol_last, busy};
        checks++;
        if (obs !== 6'b100000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", obs, 6'b100000);
        end
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] ref_seq[8] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2};
        logic [1:0] got[$];
        int first = -1;
        int last_at = -1;
        for (int c = 0; c < 11; c++) begin
            drive(c == 0, 16'hA53C, 1'b1);
            exp = model_out(1'b1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL single cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (symbol_valid) begin
                if (first < 0) first = c;
                got.push_back(symbol);
                if (symbol_last) last_at = c;
            end
            model_clock(c == 0, 16'hA53C, 1'b1);
        end
        checks++;
        if (first != 1) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=1", first);
        end
        checks++;
        if (last_at != 8) begin
            failures++;
            $display("FAIL single_last_beat got=%0d exp=8", last_at);
        end
        checks++;
        if (got.size() != 8) begin
            failures++;
            $display("FAIL single_count got=%0d exp=8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (got[k] !== ref_seq[k]) begin
                    failures++;
                    $display("FAIL single_seq beat=%0d got=%0d exp=%0d", k, got[k], ref_seq[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs[2] = '{16'hFFFF, 16'h0000};
        int phase = 0;
        int n_valid = 0;
        int first = -1;
        int last_v = -1;
        int pulse_at = -1;
        int bad_sym = 0;
        logic v;
        logic acc;
        for (int c = 0; c < 20; c++) begin
            v = (phase < 2);
            drive(v, (phase < 2) ? addrs[phase] : 16'h5A5A, 1'b1);
            exp = model_out(1'b1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (symbol_valid) begin
                if (first < 0) first = c;
                if (symbol !== ((n_valid < 8) ? SYM_T : SYM_A)) bad_sym++;
                n_valid++;
                last_v = c;
            end
            if (busy && addr_ready && pulse_at < 0) pulse_at = c;
            acc = v && exp[5];
            model_clock(v, addrs[(phase < 2) ? phase : 0], 1'b1);
            if (acc) phase++;
        end
        checks++;
        if (first != 1 || last_v != 16 || n_valid != 16 || bad_sym != 0) begin
            failures++;
            $display("FAIL b2b_stream first=%0d last=%0d count=%0d badsym=%0d exp 1/16/16/0",
                     first, last_v, n_valid, bad_sym);
        end
        checks++;
        if (pulse_at != 8) begin
            failures++;
            $display("FAIL b2b_ready_pulse got=%0d exp=8", pulse_at);
        end
    endtask

    task automatic test_backpressure();
        int n_valid = 0;
        logic [1:0] first_sym = 2'bxx;
        logic [1:0] last_sym = 2'bxx;
        int stall_bad = 0;
        logic r;
        for (int c = 0; c < 14; c++) begin
            r = !(c >= 3 && c <= 5);
            drive(c == 0, 16'h8001, r);
            exp = model_out(r);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL bp cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (symbol_valid) begin
                if (n_valid == 0) first_sym = symbol;
                if (symbol_last) last_sym = symbol;
                n_valid++;
            end
            if (c >= 3 && c <= 6 && (symbol !== 2'b00 || !symbol_valid || symbol_last)) stall_bad++;
            model_clock(c == 0, 16'h8001, r);
        end
        checks++;
        if (n_valid != 11 || first_sym !== 2'b01 || last_sym !== 2'b10 || stall_bad != 0) begin
            failures++;
            $display("FAIL bp_summary cycles=%0d first=%b last=%b stallbad=%0d exp 11/01/10/0",
                     n_valid, first_sym, last_sym, stall_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] first_sym = 2'bxx;
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 16'h1234, 1'b1);
            exp = model_out(1'b1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c < 5) model_clock(c == 0, 16'h1234, 1'b1);
        end
        #2 RST = 1'b1;
        #1;
        obs = {addr_ready, symbol_valid, symbol, symbol_last, busy};
        checks++;
        if (obs !== 6'b100000) begin
            failures++;
            $display("FAIL rst_mid_async got=%b exp=%b", obs, 6'b100000);
        end
        exp_q.delete();
        @(posedge CLK);
        #2 RST = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(c == 0, 16'h1234, 1'b1);
            exp = model_out(1'b1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rst_mid_post cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c == 1) first_sym = symbol;
            model_clock(c == 0, 16'h1234, 1'b1);
        end
        checks++;
        if (first_sym !== ref_sym(16'h1234, 0)) begin
            failures++;
            $display("FAIL rst_mid_restart got=%b exp=%b", first_sym, ref_sym(16'h1234, 0));
        end
    endtask

    task automatic test_loopback(input int iters);
        logic [1:0] syms[8];
        logic [1:0] got[$];
        logic [7:0] gx;
        logic [7:0] gy;
        logic [15:0] a;
        logic [15:0] got_v;
        logic [15:0] exp_v;
        logic accepted;
        logic v;
        logic r;
        for (int it = 0; it < iters; it++) begin
            gx = '0;
            gy = '0;
            // Address generator behaviour: each new symbol enters at the MSB.
            for (int k = 0; k < 8; k++) begin
                syms[k] = 2'($urandom_range(0, 3));
                gx = {syms[k][1], gx[7:1]};
                gy = {syms[k][0], gy[7:1]};
            end
            a = {gx, gy};
            got.delete();
            accepted = 1'b0;
            for (int c = 0; c < 60; c++) begin
                v = !accepted;
                r = ($urandom_range(0, 3) != 0);
                drive(v, a, r);
                exp = model_out(r);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL loop it=%0d cyc=%0d got=%b exp=%b", it, c, obs, exp);
                end
                if (symbol_valid && r) got.push_back(symbol);
                if (v && exp[5]) accepted = 1'b1;
                model_clock(v, a, r);
                if (got.size() == 8) break;
            end
            got_v = '0;
            exp_v = '0;
            for (int k = 0; k < 8; k++) begin
                exp_v[2*k +: 2] = syms[k];
                if (k < got.size()) got_v[2*k +: 2] = got[k];
            end
            checks++;
            if (got.size() != 8 || got_v !== exp_v) begin
                failures++;
                $display("FAIL loopback it=%0d count=%0d got=%h exp=%h", it, got.size(), got_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_loopback(1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
